ram_ctrl: RTL and testbench

Parametrised single-port synchronous RAM with a valid/ready request interface, byte-lane write enables, a configurable read pipeline, optional post-reset clear sweep and out-of-range detection. It is the next-generation instruction/data store for the microcpu, replacing the fixed 256x16 array. The core's fetch and load/store logic sit upstream and issue one request per cycle. Responses return in order after a fixed latency.

---
 rtl/ram_ctrl.sv | 173 +++++++++++++++++
 tb/tb_ram_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_ctrl.sv
// ram_ctrl: single-port synchronous RAM behind a valid/ready request port.
// Byte-lane writes, an in-order read pipeline of READ_LAT stages, an optional
// post-reset zeroing sweep and out-of-range detection for reads and writes.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  request present
//   req_ready  request accepted this cycle when high (IDLE only)
//   req_we     1 = write, 0 = read
//   req_addr   word address
//   req_wdata  write data
//   req_be     byte-lane write enables (ignored on reads)
//   rsp_valid  one-cycle pulse per accepted read, READ_LAT cycles later
//   rsp_rdata  read data, held while rsp_valid is low
//   rsp_err    read address was >= DEPTH (data is 0)
//   wr_err     one-cycle pulse: an accepted write was >= DEPTH and dropped
//   busy       clear sweep in progress
module ram_ctrl #(
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned DEPTH          = 256,
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned READ_LAT       = 1,
    parameter bit          CLEAR_ON_RESET = 1'b0,
    parameter string       INIT_FILE      = "readmem/instructions.mem"
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [DATA_W-1:0]      req_wdata,
    input  logic [DATA_W/8-1:0]    req_be,
    output logic                   rsp_valid,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   rsp_err,
    output logic                   wr_err,
    output logic                   busy
);

    localparam int unsigned BE_W   = DATA_W / 8;
    localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] ST_RESET = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_IDLE  = 2'd2;

    logic [DATA_W-1:0] mem_r [DEPTH];

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic              ready_r;
    logic              busy_r;
    logic [MEM_AW-1:0] clr_addr_r;
    logic              wr_err_r;

    logic              accept_s;
    logic              in_range_s;
    logic              wr_ok_s;
    logic              rd_acc_s;
    logic              clr_we_s;
    logic [MEM_AW-1:0] mem_idx_s;

    // Read pipeline: stage READ_LAT-1 drives the response outputs.
    logic [READ_LAT-1:0] pv_r;
    logic [READ_LAT-1:0] pe_r;
    logic [DATA_W-1:0]   pd_r [READ_LAT];

    // Compare one bit wider than the address so DEPTH == 2**ADDR_W still works.
    assign in_range_s = ({1'b0, req_addr} < (ADDR_W + 1)'(DEPTH));
    assign accept_s   = req_valid && ready_r;
    assign wr_ok_s    = accept_s && req_we && in_range_s;
    assign rd_acc_s   = accept_s && !req_we;
    assign clr_we_s   = (state_r == ST_CLEAR);
    assign mem_idx_s  = req_addr[MEM_AW-1:0];

    // Next-state decode for the RESET -> (CLEAR) -> IDLE sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RESET: begin
                if (CLEAR_ON_RESET) begin
                    state_nxt_s = ST_CLEAR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (clr_addr_r == MEM_AW'(DEPTH - 1)) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_CLEAR;
                end
            end
            ST_IDLE:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_RESET;
        endcase
    end

    // State register with registered ready/busy decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_RESET;
            ready_r    <= 1'b0;
            busy_r     <= 1'b0;
            clr_addr_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            ready_r <= (state_nxt_s == ST_IDLE);
            busy_r  <= (state_nxt_s == ST_CLEAR);
            if (clr_we_s) begin
                clr_addr_r <= clr_addr_r + MEM_AW'(1);
            end
        end
    end

    // Array write port: sweep zeroing or byte-lane request writes (never both,
    // since requests are only accepted in IDLE).
    always_ff @(posedge clk) begin
        if (clr_we_s) begin
            mem_r[clr_addr_r] <= '0;
        end else if (wr_ok_s) begin
            for (int unsigned i = 0; i < BE_W; i++) begin
                if (req_be[i]) begin
                    mem_r[mem_idx_s][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    // Read pipeline; data/err only advance with a valid token so the final
    // stage holds its last response during bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv_r <= '0;
            pe_r <= '0;
            for (int unsigned k = 0; k < READ_LAT; k++) begin
                pd_r[k] <= '0;
            end
        end else begin
            pv_r[0] <= rd_acc_s;
            if (rd_acc_s) begin
                pd_r[0] <= in_range_s ? mem_r[mem_idx_s] : '0;
                pe_r[0] <= !in_range_s;
            end
            for (int unsigned k = 1; k < READ_LAT; k++) begin
                pv_r[k] <= pv_r[k-1];
                if (pv_r[k-1]) begin
                    pd_r[k] <= pd_r[k-1];
                    pe_r[k] <= pe_r[k-1];
                end
            end
        end
    end

    // Dropped-write flag, one cycle after the out-of-range write is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_err_r <= 1'b0;
        end else begin
            wr_err_r <= accept_s && req_we && !in_range_s;
        end
    end

    assign req_ready = ready_r;
    assign busy      = busy_r;
    assign rsp_valid = pv_r[READ_LAT-1];
    assign rsp_rdata = pd_r[READ_LAT-1];
    assign rsp_err   = pe_r[READ_LAT-1];
    assign wr_err    = wr_err_r;

endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: three ram_ctrl instances sharing one clock.
//   u=0: DEPTH 256, READ_LAT 1, no clear
//   u=1: DEPTH 200, READ_LAT 3, clear on reset
//   u=2: DEPTH 200, READ_LAT 4, no clear
// A behavioural memory model plus per-instance expected-response rings are
// checked every falling edge; directed steps then random traffic.
module tb_ram_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]       rst_n;
    logic [2:0]       req_valid, req_we, req_ready, rsp_valid, rsp_err, wr_err, busy;
    logic [2:0][15:0] req_addr, req_wdata, rsp_rdata;
    logic [2:0][1:0]  req_be;

    int errors = 0;
    int checks = 0;
    int edge_cnt = 0;
    int DEP [3] = '{256, 200, 200};
    int LAT [3] = '{1, 3, 4};

    typedef struct {
        int          due;
        logic [15:0] d;
        logic        e;
    } rsp_t;

    logic [15:0] mm    [3][256];
    bit          known [3][256];
    rsp_t        rb    [3][64];
    int          rwr [3], rrd [3];
    int          wq  [3][16];
    int          wwr [3], wrd [3];
    logic [15:0] last_rd [3];

    ram_ctrl #(.DATA_W(16), .DEPTH(256), .ADDR_W(16), .READ_LAT(1),
               .CLEAR_ON_RESET(1'b0), .INIT_FILE("")) u_a (
        .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
        .wr_err(wr_err[0]), .busy(busy[0]));

    ram_ctrl #(.DATA_W(16), .DEPTH(200), .ADDR_W(16), .READ_LAT(3),
               .CLEAR_ON_RESET(1'b1), .INIT_FILE("")) u_b (
        .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
        .wr_err(wr_err[1]), .busy(busy[1]));

    ram_ctrl #(.DATA_W(16), .DEPTH(200), .ADDR_W(16), .READ_LAT(4),
               .CLEAR_ON_RESET(1'b0), .INIT_FILE("")) u_c (
        .clk(clk), .rst_n(rst_n[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_we(req_we[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_be(req_be[2]),
        .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]),
        .wr_err(wr_err[2]), .busy(busy[2]));

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Response / wr_err monitor against the expected rings.
    always @(negedge clk) begin
        for (int u = 0; u < 3; u++) begin
            bit ev;
            bit ew;
            ev = (rrd[u] != rwr[u]) && (rb[u][rrd[u] % 64].due == edge_cnt);
            checks++;
            assert (rsp_valid[u] === ev) else begin
                errors++;
                $error("FAIL rsp_valid[%0d] at edge %0d: got %b expected %b", u, edge_cnt, rsp_valid[u], ev);
            end
            if (ev) begin
                checks++;
                assert (rsp_rdata[u] === rb[u][rrd[u] % 64].d) else begin
                    errors++;
                    $error("FAIL rsp_rdata[%0d] at edge %0d: got %h expected %h", u, edge_cnt, rsp_rdata[u], rb[u][rrd[u] % 64].d);
                end
                checks++;
                assert (rsp_err[u] === rb[u][rrd[u] % 64].e) else begin
                    errors++;
                    $error("FAIL rsp_err[%0d] at edge %0d: got %b expected %b", u, edge_cnt, rsp_err[u], rb[u][rrd[u] % 64].e);
                end
                last_rd[u] = rb[u][rrd[u] % 64].d;
                rrd[u]++;
            end else begin
                checks++;
                assert (rsp_rdata[u] === last_rd[u]) else begin
                    errors++;
                    $error("FAIL rdata_hold[%0d] at edge %0d: got %h expected %h", u, edge_cnt, rsp_rdata[u], last_rd[u]);
                end
            end
            ew = (wrd[u] != wwr[u]) && (wq[u][wrd[u] % 16] == edge_cnt);
            checks++;
            assert (wr_err[u] === ew) else begin
                errors++;
                $error("FAIL wr_err[%0d] at edge %0d: got %b expected %b", u, edge_cnt, wr_err[u], ew);
            end
            if (ew) wrd[u]++;
        end
    end

    // One request; waits (bounded) for ready, updates the model, holds one cycle.
    task automatic do_req(input int u, input bit we, input int addr, input logic [15:0] wd,
                          input logic [1:0] be, input bit use_exp, input logic [15:0] exp_d,
                          input bit exp_e);
        int waits = 0;
        while (req_ready[u] !== 1'b1 && waits < 1000) begin
            @(posedge clk); #1;
            waits++;
        end
        checks++;
        assert (req_ready[u] === 1'b1) else begin
            errors++;
            $error("FAIL ready_wait[%0d]: got %b expected 1", u, req_ready[u]);
        end
        if (req_ready[u] === 1'b1) begin
            req_valid[u] = 1'b1;
            req_we[u]    = we;
            req_addr[u]  = 16'(addr);
            req_wdata[u] = wd;
            req_be[u]    = be;
            if (we) begin
                if (addr < DEP[u]) begin
                    for (int i = 0; i < 2; i++) begin
                        if (be[i]) mm[u][addr][8*i +: 8] = wd[8*i +: 8];
                    end
                    if (be == 2'b11) known[u][addr] = 1'b1;
                end else begin
                    wq[u][wwr[u] % 16] = edge_cnt + 1;
                    wwr[u]++;
                end
            end else begin
                rsp_t r;
                r.due = edge_cnt + LAT[u];
                if (use_exp) begin
                    r.d = exp_d;
                    r.e = exp_e;
                end else if (addr < DEP[u]) begin
                    r.d = mm[u][addr];
                    r.e = 1'b0;
                end else begin
                    r.d = 16'h0000;
                    r.e = 1'b1;
                end
                rb[u][rwr[u] % 64] = r;
                rwr[u]++;
            end
            @(posedge clk); #1;
            req_valid[u] = 1'b0;
        end
    endtask

    task automatic wr(input int u, input int addr, input logic [15:0] d, input logic [1:0] be);
        do_req(u, 1'b1, addr, d, be, 1'b0, 16'h0000, 1'b0);
    endtask

    task automatic rd(input int u, input int addr);
        do_req(u, 1'b0, addr, 16'h0000, 2'b00, 1'b0, 16'h0000, 1'b0);
    endtask

    task automatic rdx(input int u, input int addr, input logic [15:0] d, input bit e);
        do_req(u, 1'b0, addr, 16'h0000, 2'b00, 1'b1, d, e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic reset_inst(input int u);
        rst_n[u]     = 1'b0;
        req_valid[u] = 1'b0;
        rrd[u]       = rwr[u];
        wrd[u]       = wwr[u];
        last_rd[u]   = 16'h0000;
    endtask

    task automatic chk_rst(input int u, input string tag);
        checks++;
        assert ({req_ready[u], rsp_valid[u], rsp_err[u], wr_err[u], busy[u], rsp_rdata[u]} === 21'd0) else begin
            errors++;
            $error("FAIL %s[%0d]: got ready=%b valid=%b err=%b wr_err=%b busy=%b rdata=%h expected all 0",
                   tag, u, req_ready[u], rsp_valid[u], rsp_err[u], wr_err[u], busy[u], rsp_rdata[u]);
        end
    endtask

    // Counts cycles of instance 1 with busy=1 and req_ready=0 until ready rises.
    task automatic sweep_count(input string tag);
        int n = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (busy[1] === 1'b1 && req_ready[1] === 1'b0) n++;
            if (req_ready[1] === 1'b1) break;
        end
        checks++;
        assert (n == 200) else begin
            errors++;
            $error("FAIL %s: got %0d busy cycles expected 200", tag, n);
        end
        @(posedge clk); #1;
        checks++;
        assert (busy[1] === 1'b0 && req_ready[1] === 1'b1) else begin
            errors++;
            $error("FAIL %s_end: got busy=%b ready=%b expected busy=0 ready=1", tag, busy[1], req_ready[1]);
        end
        for (int a = 0; a < 200; a++) begin
            mm[1][a]    = 16'h0000;
            known[1][a] = 1'b1;
        end
    endtask

    initial begin
        rst_n     = 3'b000;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        for (int u = 0; u < 3; u++) begin
            rwr[u] = 0; rrd[u] = 0; wwr[u] = 0; wrd[u] = 0;
            last_rd[u] = 16'h0000;
            for (int a = 0; a < 256; a++) begin
                mm[u][a]    = 16'h0000;
                known[u][a] = 1'b0;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 3; u++) chk_rst(u, "reset_state");

        // Release all; instance 1 sweeps its 200 words.
        rst_n = 3'b111;
        sweep_count("clear_sweep");

        // Fill instance 0 so every address has a known value.
        for (int a = 0; a < 256; a++) wr(0, a, 16'($urandom), 2'b11);

        // Basic write/read and byte enables.
        wr(0, 16'h10, 16'hBEEF, 2'b11);
        rdx(0, 16'h10, 16'hBEEF, 1'b0);
        idle(2);
        wr(0, 5, 16'h1234, 2'b11);
        wr(0, 5, 16'hAB00, 2'b10);
        rdx(0, 5, 16'hAB34, 1'b0);
        wr(0, 6, 16'h5A5A, 2'b11);
        wr(0, 6, 16'hFFFF, 2'b00);
        rdx(0, 6, 16'h5A5A, 1'b0);
        wr(0, 16'hFFFF, 16'h1111, 2'b11);
        rdx(0, 256, 16'h0000, 1'b1);
        idle(3);

        // Cleared word, then READ_LAT=3 back-to-back reads.
        rdx(1, 199, 16'h0000, 1'b0);
        for (int a = 0; a < 4; a++) wr(1, a, 16'(16'h00A0 + a), 2'b11);
        for (int a = 0; a < 4; a++) rdx(1, a, 16'(16'h00A0 + a), 1'b0);
        idle(5);

        // Out of range on DEPTH=200.
        wr(1, 200, 16'h5555, 2'b11);
        rdx(1, 0, 16'h00A0, 1'b0);
        rdx(1, 72, 16'h0000, 1'b0);
        rdx(1, 250, 16'h0000, 1'b1);
        idle(5);

        // Reset with two READ_LAT=4 reads in flight.
        wr(2, 1, 16'h1111, 2'b11);
        wr(2, 2, 16'h2222, 2'b11);
        rd(2, 1);
        rd(2, 2);
        reset_inst(2);
        #1;
        chk_rst(2, "inflight_reset");
        repeat (5) @(negedge clk);
        chk_rst(2, "inflight_hold");
        @(posedge clk); #1;
        rst_n[2] = 1'b1;
        idle(12);
        rdx(2, 2, 16'h2222, 1'b0);
        idle(5);

        // Reset 50 cycles into a sweep; the full sweep must restart.
        wr(1, 7, 16'hDEAD, 2'b11);
        reset_inst(1);
        idle(2);
        rst_n[1] = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        checks++;
        assert (busy[1] === 1'b1 && req_ready[1] === 1'b0) else begin
            errors++;
            $error("FAIL mid_sweep: got busy=%b ready=%b expected busy=1 ready=0", busy[1], req_ready[1]);
        end
        reset_inst(1);
        #1;
        chk_rst(1, "sweep_abort");
        @(posedge clk); #1;
        rst_n[1] = 1'b1;
        sweep_count("sweep_restart");
        rdx(1, 7, 16'h0000, 1'b0);
        idle(5);

        // Random traffic on each instance against the model.
        for (int u = 0; u < 3; u++) begin
            for (int k = 0; k < 150; k++) begin
                bit          we;
                int          a;
                logic [1:0]  be;
                if ($urandom_range(0, 9) == 0) begin
                    idle(1);
                end else begin
                    we = 1'($urandom_range(0, 1));
                    a  = $urandom_range(0, DEP[u] + 40);
                    be = 2'($urandom_range(0, 3));
                    if (!we && a < DEP[u] && !known[u][a]) begin
                        we = 1'b1;
                        be = 2'b11;
                    end
                    do_req(u, we, a, 16'($urandom), be, 1'b0, 16'h0000, 1'b0);
                end
            end
            idle(6);
        end

        idle(10);
        for (int u = 0; u < 3; u++) begin
            checks++;
            assert (rrd[u] == rwr[u] && wrd[u] == wwr[u]) else begin
                errors++;
                $error("FAIL drain[%0d]: got %0d responses outstanding expected 0", u, rwr[u] - rrd[u]);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
